// File: rtl/bsearch_guesser.sv
// Successive-approximation controller closing the loop around a magnitude comparator.
// Drives a registered guess each cycle and binary-searches on gt/lt/eq until a hit or an empty range.
module bsearch_guesser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] tries,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   ONE_X      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Handshake: start is honoured only in IDLE or DONE; done is a level held
    // until the next accepted start, and found/error are meaningful only with done.

    state_e           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, tries_q, tries_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             found_q, found_d, error_q, error_d;

    logic [WIDTH:0]   guess_ext, lo_inc, hi_dec, mid_gt_sum, mid_lt_sum;
    logic             one_hot;

    always_comb begin
        guess_ext  = {1'b0, guess_q};
        lo_inc     = guess_ext + ONE_X;
        hi_dec     = guess_ext - ONE_X;
        // Sums are WIDTH+1 bits wide so lo = 2^WIDTH never wraps the midpoint.
        mid_gt_sum = lo_inc + hi_q;
        mid_lt_sum = lo_q + hi_dec;
        one_hot    = (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);

        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        tries_d = tries_q;
        busy_d  = busy_q;
        done_d  = done_q;
        found_d = found_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PROBE;
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    guess_d = GUESS_INIT;
                    tries_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    found_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_PROBE: begin
                tries_d = tries_q + ONE_W;
                if (!one_hot) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    error_d = 1'b1;
                end else if (eq) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                end else if (gt) begin
                    lo_d = lo_inc;
                    if (lo_inc > hi_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        found_d = 1'b0;
                    end else begin
                        guess_d = mid_gt_sum[WIDTH:1];
                    end
                end else begin
                    // A secret below zero cannot exist; stop rather than underflow hi.
                    if (guess_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        found_d = 1'b0;
                    end else begin
                        hi_d = hi_dec;
                        if (lo_q > hi_dec) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            found_d = 1'b0;
                        end else begin
                            guess_d = mid_lt_sum[WIDTH:1];
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            guess_q <= '0;
            tries_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            tries_q <= tries_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            error_q <= error_d;
        end
    end

    assign guess     = guess_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign error     = error_q;
    assign tries     = tries_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bsearch_guesser.sv
// Directed bench for bsearch_guesser: a behavioural comparator closes the loop and
// each probe, final result and reset behaviour is checked against hand-derived values.
module tb_bsearch_guesser;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       gt, lt, eq;
    logic [3:0] guess, tries;
    logic       busy, done, found, error;
    logic [1:0] dbg_state;

    logic [3:0] f;
    int         mode;
    int         n_vec;
    int         n_err;

    bsearch_guesser #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .guess     (guess),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .error     (error),
        .tries     (tries),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: true comparator; 1: gt and lt both set; 2: claims lt whenever guess is 0
    always_comb begin
        gt = (f > guess);
        lt = (f < guess);
        eq = (f == guess);
        if (mode == 1) begin
            gt = 1'b1;
            lt = 1'b1;
            eq = 1'b0;
        end else if (mode == 2 && guess == 4'd0) begin
            gt = 1'b0;
            lt = 1'b1;
            eq = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [3:0] exp_guess, input logic [3:0] exp_tries);
        chk({tag, " busy"},  {7'd0, busy}, 8'd1);
        chk({tag, " done"},  {7'd0, done}, 8'd0);
        chk({tag, " guess"}, {4'd0, guess}, {4'd0, exp_guess});
        chk({tag, " tries"}, {4'd0, tries}, {4'd0, exp_tries});
        tick();
    endtask

    task automatic fin(input string tag, input logic exp_found, input logic exp_error,
                       input logic [3:0] exp_guess, input logic [3:0] exp_tries);
        chk({tag, " done"},  {7'd0, done}, 8'd1);
        chk({tag, " busy"},  {7'd0, busy}, 8'd0);
        chk({tag, " found"}, {7'd0, found}, {7'd0, exp_found});
        chk({tag, " error"}, {7'd0, error}, {7'd0, exp_error});
        chk({tag, " guess"}, {4'd0, guess}, {4'd0, exp_guess});
        chk({tag, " tries"}, {4'd0, tries}, {4'd0, exp_tries});
        chk({tag, " state"}, {6'd0, dbg_state}, 8'd2);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " guess"}, {4'd0, guess}, 8'd0);
        chk({tag, " busy"},  {7'd0, busy}, 8'd0);
        chk({tag, " done"},  {7'd0, done}, 8'd0);
        chk({tag, " found"}, {7'd0, found}, 8'd0);
        chk({tag, " error"}, {7'd0, error}, 8'd0);
        chk({tag, " tries"}, {4'd0, tries}, 8'd0);
        chk({tag, " state"}, {6'd0, dbg_state}, 8'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        f     = 4'd0;
        mode  = 0;
        #3;
        all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        all_zero("idle");

        // f=5: 7 lt, 3 gt, 5 eq
        f = 4'd5;
        do_start();
        probe("f5 p0", 4'd7, 4'd0);
        probe("f5 p1", 4'd3, 4'd1);
        probe("f5 p2", 4'd5, 4'd2);
        fin("f5 end", 1'b1, 1'b0, 4'd5, 4'd3);
        tick();
        tick();
        fin("f5 hold", 1'b1, 1'b0, 4'd5, 4'd3);

        // f=15: lo climbs to 15 with no wrap
        f = 4'd15;
        do_start();
        probe("f15 p0", 4'd7, 4'd0);
        probe("f15 p1", 4'd11, 4'd1);
        probe("f15 p2", 4'd13, 4'd2);
        probe("f15 p3", 4'd14, 4'd3);
        probe("f15 p4", 4'd15, 4'd4);
        fin("f15 end", 1'b1, 1'b0, 4'd15, 4'd5);

        // f=0: 7, 3, 1, 0
        f = 4'd0;
        do_start();
        probe("f0 p0", 4'd7, 4'd0);
        probe("f0 p1", 4'd3, 4'd1);
        probe("f0 p2", 4'd1, 4'd2);
        probe("f0 p3", 4'd0, 4'd3);
        fin("f0 end", 1'b1, 1'b0, 4'd0, 4'd4);

        // lt at guess 0 must stop without underflow
        mode = 2;
        do_start();
        probe("lt0 p0", 4'd7, 4'd0);
        probe("lt0 p1", 4'd3, 4'd1);
        probe("lt0 p2", 4'd1, 4'd2);
        probe("lt0 p3", 4'd0, 4'd3);
        fin("lt0 end", 1'b0, 1'b0, 4'd0, 4'd4);

        // gt and lt together on first probe
        mode = 1;
        do_start();
        probe("err p0", 4'd7, 4'd0);
        fin("err end", 1'b0, 1'b1, 4'd7, 4'd1);
        mode = 0;

        // back-to-back: f=5 then f=3 started straight from DONE
        f = 4'd5;
        do_start();
        probe("b2b1 p0", 4'd7, 4'd0);
        start = 1'b1;
        probe("b2b1 p1", 4'd3, 4'd1);
        start = 1'b0;
        probe("b2b1 p2", 4'd5, 4'd2);
        fin("b2b1 end", 1'b1, 1'b0, 4'd5, 4'd3);
        f = 4'd3;
        do_start();
        chk("b2b2 done drop", {7'd0, done}, 8'd0);
        start = 1'b1;
        probe("b2b2 p0", 4'd7, 4'd0);
        start = 1'b0;
        probe("b2b2 p1", 4'd3, 4'd1);
        fin("b2b2 end", 1'b1, 1'b0, 4'd3, 4'd2);

        // reset asserted during the second probe of an f=15 search
        f = 4'd15;
        do_start();
        probe("rst p0", 4'd7, 4'd0);
        chk("rst p1 guess", {4'd0, guess}, 8'd11);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("rst async");
        tick();
        all_zero("rst held");
        #3;
        rst_n = 1'b1;
        tick();
        all_zero("rst rel1");
        tick();
        all_zero("rst rel2");

        do_start();
        probe("post p0", 4'd7, 4'd0);
        probe("post p1", 4'd11, 4'd1);
        probe("post p2", 4'd13, 4'd2);
        probe("post p3", 4'd14, 4'd3);
        probe("post p4", 4'd15, 4'd4);
        fin("post end", 1'b1, 1'b0, 4'd15, 4'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
